// File: rtl/duck_pkg.sv
// Shared types and constants for the L4 duck stream connectivity layer.
// The sync constants are used by reference models of the Berry-phase lock.
package duck_pkg;

  localparam int          HASH_W_DEFAULT   = 256;
  localparam logic [15:0] PHI_SYNC_RATE    = 16'h0578;
  localparam logic [15:0] SYNC_LOCK_THRESH = 16'hF000;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_LOCK = 2'd1,
    BURST     = 2'd2
  } arb_state_t;

endpackage

// File: rtl/duck_rr_picker.sv
// Combinational round-robin picker: first set request at or after the pointer,
// wrapping around.
module duck_rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IW-1:0]      i_ptr,
  output logic [IW-1:0]      o_idx,
  output logic               o_any
);

  logic w_found;
  int   w_pos;

  always_comb begin
    o_any   = |i_req;
    o_idx   = '0;
    w_found = 1'b0;
    w_pos   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_pos = (int'(i_ptr) + k) % NUM_REQ;
      if (!w_found && i_req[w_pos]) begin
        o_idx   = IW'(w_pos);
        w_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/duck_stream_arbiter.sv
// Round-robin arbiter sharing the duck stream hash input between producers;
// bursts start inside a sync window or after a bounded lock timeout.
module duck_stream_arbiter
  import duck_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int HASH_W       = HASH_W_DEFAULT,
  parameter int BURST_LEN    = 8,
  parameter int LOCK_TIMEOUT = 64,
  parameter int IW           = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*HASH_W-1:0] req_hash,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      sync_lock,
  output logic [HASH_W-1:0]         stream_hash,
  output logic                      stream_valid,
  output logic [IW-1:0]             grant_id,
  output logic                      busy,
  output logic                      lock_timeout,
  input  logic                      clear_err,
  output arb_state_t                dbg_state
);

  // Handshake: a hash moves when req_valid[g] & req_ready[g]; req_ready is a
  // pure function of state registers, so producers see no combinational loop.
  localparam int WW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  arb_state_t          r_state, w_state_nxt;
  logic [IW-1:0]       r_grant, w_grant_nxt;
  logic [IW-1:0]       r_rr_ptr, w_rr_nxt;
  logic [BW-1:0]       r_beat_cnt, w_beat_nxt;
  logic [WW-1:0]       r_wait_cnt, w_wait_nxt;
  logic [HASH_W-1:0]   r_stream_hash;
  logic                r_stream_valid;
  logic                r_lock_timeout;
  logic                w_set_to;
  logic                w_xfer;
  logic [IW-1:0]       w_win;
  logic                w_any;

  duck_rr_picker #(.NUM_REQ(NUM_REQ), .IW(IW)) u_picker (
    .i_req (req_valid),
    .i_ptr (r_rr_ptr),
    .o_idx (w_win),
    .o_any (w_any)
  );

  assign w_xfer = (r_state == BURST) && req_valid[r_grant];

  always_comb begin
    req_ready = '0;
    if (r_state == BURST) req_ready[r_grant] = 1'b1;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_rr_nxt    = r_rr_ptr;
    w_beat_nxt  = r_beat_cnt;
    w_wait_nxt  = r_wait_cnt;
    w_set_to    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_grant_nxt = w_win;
          w_wait_nxt  = '0;
          w_state_nxt = WAIT_LOCK;
        end
      end
      WAIT_LOCK: begin
        if (!req_valid[r_grant]) begin
          w_state_nxt = IDLE;
        end else if (sync_lock) begin
          w_state_nxt = BURST;
        end else if (r_wait_cnt == WW'(LOCK_TIMEOUT - 1)) begin
          w_state_nxt = BURST;
          w_set_to    = 1'b1;
        end else begin
          w_wait_nxt = r_wait_cnt + 1'b1;
        end
      end
      BURST: begin
        if (w_xfer && (r_beat_cnt != BW'(BURST_LEN - 1))) begin
          w_beat_nxt = r_beat_cnt + 1'b1;
        end else begin
          // Burst ends on the last beat or when the producer stalls.
          w_beat_nxt  = '0;
          w_rr_nxt    = (r_grant == IW'(NUM_REQ - 1)) ? '0 : r_grant + 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_grant        <= '0;
      r_rr_ptr       <= '0;
      r_beat_cnt     <= '0;
      r_wait_cnt     <= '0;
      r_stream_hash  <= '0;
      r_stream_valid <= 1'b0;
      r_lock_timeout <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_grant        <= w_grant_nxt;
      r_rr_ptr       <= w_rr_nxt;
      r_beat_cnt     <= w_beat_nxt;
      r_wait_cnt     <= w_wait_nxt;
      r_stream_valid <= w_xfer;
      if (w_xfer) r_stream_hash <= req_hash[r_grant*HASH_W +: HASH_W];
      if (w_set_to)       r_lock_timeout <= 1'b1;
      else if (clear_err) r_lock_timeout <= 1'b0;
    end
  end

  assign stream_hash  = r_stream_hash;
  assign stream_valid = r_stream_valid;
  assign grant_id     = r_grant;
  assign busy         = (r_state != IDLE);
  assign lock_timeout = r_lock_timeout;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_duck_stream_arbiter.sv
// Directed bench for duck_stream_arbiter: round-robin order, sync/timeout
// start, withdrawal, async reset mid-burst and short bursts.
module tb_duck_stream_arbiter;
  import duck_pkg::*;

  localparam int N  = 4;
  localparam int HW = 256;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N*HW-1:0] req_hash;
  logic [N-1:0]    req_ready;
  logic            sync_lock;
  logic [HW-1:0]   stream_hash;
  logic            stream_valid;
  logic [1:0]      grant_id;
  logic            busy;
  logic            lock_timeout;
  logic            clear_err;
  arb_state_t      dbg_state;

  int n_vec = 0;
  int n_err = 0;

  duck_stream_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_hash     (req_hash),
    .req_ready    (req_ready),
    .sync_lock    (sync_lock),
    .stream_hash  (stream_hash),
    .stream_valid (stream_valid),
    .grant_id     (grant_id),
    .busy         (busy),
    .lock_timeout (lock_timeout),
    .clear_err    (clear_err),
    .dbg_state    (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [HW-1:0] pat(input logic [7:0] b);
    return {32{b}};
  endfunction

  task automatic chk(input string tag, input logic [HW-1:0] obs, input logic [HW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one clock, then settle away from the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_hash(input int r, input logic [HW-1:0] h);
    req_hash[r*HW +: HW] = h;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_hash"}, stream_hash, '0);
    chk({tag, "_valid"}, HW'(stream_valid), '0);
    chk({tag, "_grant"}, HW'(grant_id), '0);
    chk({tag, "_lto"}, HW'(lock_timeout), '0);
    chk({tag, "_ready"}, HW'(req_ready), '0);
    chk({tag, "_busy"}, HW'(busy), '0);
  endtask

  initial begin
    int g;
    int n_wait;
    logic [3:0] rdy_exp;

    rst_n = 1'b0; req_valid = '0; req_hash = '0; sync_lock = 1'b0; clear_err = 1'b0;
    #3;
    chk_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // All requesters valid, lock high: 0,1,2,3,0 with 8-beat bursts
    for (int r = 0; r < N; r++) set_hash(r, pat(8'hB0 + 8'(r)));
    req_valid = 4'b1111;
    sync_lock = 1'b1;
    for (int b = 0; b < 5; b++) begin
      g = b % N;
      rdy_exp = 4'b0001 << g;
      step();
      chk("rr_grant", HW'(grant_id), HW'(g));
      chk("rr_wait_state", HW'(dbg_state), HW'(WAIT_LOCK));
      chk("rr_gap1_valid", HW'(stream_valid), '0);
      step();
      chk("rr_burst_state", HW'(dbg_state), HW'(BURST));
      chk("rr_gap2_valid", HW'(stream_valid), '0);
      chk("rr_ready", HW'(req_ready), HW'(rdy_exp));
      for (int k = 0; k < 8; k++) begin
        step();
        chk("rr_beat_valid", HW'(stream_valid), HW'(1));
        chk("rr_beat_hash", stream_hash, pat(8'hB0 + 8'(g)));
      end
      chk("rr_end_busy", HW'(busy), '0);
    end
    req_valid = '0;
    sync_lock = 1'b0;

    // Single requester, lock arrives late, 3 hashes then valid drops
    set_hash(0, pat(8'hA1));
    req_valid = 4'b0001;
    chk("s1_busy_before", HW'(busy), '0);
    step();
    chk("s1_busy_after", HW'(busy), HW'(1));
    chk("s1_grant", HW'(grant_id), '0);
    chk("s1_ready_wait", HW'(req_ready), '0);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("s1_still_wait", HW'(dbg_state), HW'(WAIT_LOCK));
    end
    sync_lock = 1'b1;
    step();
    chk("s1_burst", HW'(dbg_state), HW'(BURST));
    chk("s1_no_valid_yet", HW'(stream_valid), '0);
    step();
    chk("s1_v1", HW'(stream_valid), HW'(1));
    chk("s1_h1", stream_hash, pat(8'hA1));
    set_hash(0, pat(8'hA2));
    step();
    chk("s1_v2", HW'(stream_valid), HW'(1));
    chk("s1_h2", stream_hash, pat(8'hA2));
    set_hash(0, pat(8'hA3));
    step();
    chk("s1_v3", HW'(stream_valid), HW'(1));
    chk("s1_h3", stream_hash, pat(8'hA3));
    req_valid = '0;
    step();
    chk("s1_end_valid", HW'(stream_valid), '0);
    chk("s1_hold_hash", stream_hash, pat(8'hA3));
    chk("s1_idle", HW'(busy), '0);
    chk("s1_lto", HW'(lock_timeout), '0);

    // Lock never arrives: forced start after 64 cycles in WAIT_LOCK
    sync_lock = 1'b0;
    req_valid = 4'b0100;
    step();
    chk("to_grant", HW'(grant_id), HW'(2));
    n_wait = 1;
    for (int c = 0; c < 200; c++) begin
      step();
      if (dbg_state != WAIT_LOCK) break;
      n_wait++;
    end
    chk("to_wait_cycles", HW'(n_wait), HW'(64));
    chk("to_burst", HW'(dbg_state), HW'(BURST));
    chk("to_grant_burst", HW'(grant_id), HW'(2));
    chk("to_lto_set", HW'(lock_timeout), HW'(1));
    req_valid = '0;
    step();
    chk("to_idle", HW'(busy), '0);
    chk("to_lto_sticky", HW'(lock_timeout), HW'(1));
    chk("to_no_valid", HW'(stream_valid), '0);
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    chk("to_lto_clear", HW'(lock_timeout), '0);

    // Requester 1 withdraws in WAIT_LOCK; requester 3 is next
    req_valid = 4'b0010;
    step();
    chk("wd_grant1", HW'(grant_id), HW'(1));
    step();
    step();
    req_valid = 4'b1001;
    step();
    chk("wd_idle", HW'(busy), '0);
    chk("wd_no_valid", HW'(stream_valid), '0);
    chk("wd_grant_hold", HW'(grant_id), HW'(1));
    step();
    chk("wd_grant3", HW'(grant_id), HW'(3));

    // Async reset after beat 4 of requester 3's burst
    sync_lock = 1'b1;
    step();
    chk("ar_burst", HW'(dbg_state), HW'(BURST));
    for (int k = 0; k < 4; k++) begin
      set_hash(3, pat(8'hC0 + 8'(k)));
      step();
      chk("ar_beat_hash", stream_hash, pat(8'hC0 + 8'(k)));
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("ar_async");
    @(posedge clk); #1;
    chk("ar_held_valid", HW'(stream_valid), '0);
    rst_n = 1'b1;
    step();
    chk("ar_restart_grant", HW'(grant_id), '0);

    // Short burst: requester 0 stops after 2 beats, pointer moves past it
    step();
    chk("sh_burst", HW'(dbg_state), HW'(BURST));
    set_hash(0, pat(8'hD1));
    step();
    chk("sh_v1", HW'(stream_valid), HW'(1));
    chk("sh_h1", stream_hash, pat(8'hD1));
    set_hash(0, pat(8'hD2));
    step();
    chk("sh_v2", HW'(stream_valid), HW'(1));
    chk("sh_h2", stream_hash, pat(8'hD2));
    req_valid = 4'b1000;
    step();
    chk("sh_no_third", HW'(stream_valid), '0);
    chk("sh_idle", HW'(busy), '0);
    req_valid = 4'b1001;
    step();
    chk("sh_rr_advanced", HW'(grant_id), HW'(3));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/duck_stream_arbiter.md
Name: duck_stream_arbiter

Overview:
- Shares the single L4 duck stream hash path between NUM_REQ hash producers.
- Picks one requester round-robin. Starts its burst only inside a Berry-phase sync window (sync_lock high), or after a bounded timeout.
- Forwards up to BURST_LEN hashes per grant through a registered output stage into the stream's hash input.
- Sits between the hashing cores and the duck stream instance in the L4 connectivity layer.

Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- HASH_W, 256: hash width in bits.
- BURST_LEN, 8: maximum beats per grant, at least 1.
- LOCK_TIMEOUT, 64: cycles to wait in WAIT_LOCK before forcing the burst start, at least 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester hash valid.
- req_hash  in  NUM_REQ*HASH_W  packed hashes; requester i occupies bits [i*HASH_W +: HASH_W].
- req_ready  out  NUM_REQ  per-requester accept, one-hot or zero.
- sync_lock  in  1  Berry-phase lock from the duck stream.
- stream_hash  out  HASH_W  registered hash toward the duck stream.
- stream_valid  out  1  one-cycle pulse per forwarded hash.
- grant_id  out  $clog2(NUM_REQ)  current or last granted requester.
- busy  out  1  high whenever state is not IDLE.
- lock_timeout  out  1  sticky flag: a burst was force-started without lock.
- clear_err  in  1  synchronous clear of lock_timeout.

Behaviour:
- Reset values (asynchronous, while rst_n=0):
  - state=IDLE.
  - All outputs 0: stream_hash, stream_valid, grant_id, lock_timeout, req_ready.
  - rr_ptr=0, beat_cnt=0, wait_cnt=0.
- req_ready:
  - Decoded from state registers only: req_ready[grant_id] is 1 only in BURST.
  - No combinational path from req_valid or sync_lock.
- Transfer = req_valid[g] & req_ready[g], where g = grant_id.
- IDLE:
  - If any req_valid is set, the round-robin winner is the first set bit at or after rr_ptr, with wrap.
  - Latch the winner into grant_id, clear wait_cnt, go to WAIT_LOCK.
- WAIT_LOCK:
  - If req_valid[g]=0, go to IDLE (re-arbitrate next cycle; rr_ptr unchanged).
  - Else if sync_lock=1, go to BURST.
  - Else if wait_cnt==LOCK_TIMEOUT-1, go to BURST and set lock_timeout.
  - Else increment wait_cnt.
- BURST:
  - On each transfer, capture req_hash slice g into stream_hash and pulse stream_valid the next cycle. Latency from transfer to output is 1 cycle.
  - On a transfer, increment beat_cnt.
  - The burst ends when a transfer occurs with beat_cnt==BURST_LEN-1, or when req_valid[g]=0 (no transfer that cycle).
  - On burst end: rr_ptr = (g+1) mod NUM_REQ, beat_cnt=0, go to IDLE.
  - sync_lock is ignored during BURST.
- stream_hash holds its last value when no transfer occurs. stream_valid=0 when no transfer occurs.
- grant_id holds its last value in IDLE.
- IDLE always costs one cycle, so back-to-back bursts have a minimum 2-cycle gap (IDLE plus WAIT_LOCK with lock already high).
- lock_timeout: set has priority over clear_err in the same cycle. It is cleared only by clear_err or reset.
- Reset mid-burst: everything returns to reset values immediately, and no stream_valid is emitted afterwards.
- The timeout counter is wide enough for LOCK_TIMEOUT-1 and saturates; it never wraps.

Decomposition:
- Shared package duck_pkg:
  - HASH_W_DEFAULT=256.
  - PHI_SYNC_RATE=16'h0578 and SYNC_LOCK_THRESH=16'hF000, for bench reference models.
  - State enum arb_state_t {IDLE, WAIT_LOCK, BURST}.
- Sub-module duck_rr_picker: combinational round-robin priority picker.
  - Inputs: request vector and rr_ptr.
  - Outputs: winner index and any-flag.

Test Plan:
- Single requester: req_valid=4'b0001, 3 hashes 0xA1.., 0xA2.., 0xA3.., then valid drops; sync_lock high from cycle 5. Expected:
  - busy rises the cycle after valid.
  - The burst starts the cycle sync_lock is seen.
  - stream_valid pulses 3 times with hashes in order, each 1 cycle after its transfer.
  - Returns to IDLE; lock_timeout=0.
- All 4 requesters continuously valid, sync_lock=1. Expected:
  - Grant order 0,1,2,3,0.
  - Each burst is exactly BURST_LEN=8 beats.
  - 2-cycle gap between bursts.
- Lock never arrives: sync_lock=0, req 2 valid. Expected:
  - Exactly 64 cycles in WAIT_LOCK, then BURST with grant_id=2.
  - lock_timeout=1 and stays set.
  - A clear_err pulse clears it.
- Requester withdraws: req 1 valid, then valid dropped at cycle 3 of WAIT_LOCK. Expected:
  - IDLE with no stream_valid.
  - Requester 3, valid, is granted next.
- Asynchronous reset asserted mid-burst after beat 4. Expected:
  - All outputs go to 0 immediately, without a clock edge.
  - After release, arbitration restarts from rr_ptr=0.
- Short requester: valid drops after beat 2 of the burst. Expected:
  - Exactly 2 stream_valid pulses.
  - rr_ptr advances past this requester.
